// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexing scheduler for a shared 4-digit 7-segment display.
//   Each digit gets a fixed slot of REFRESH_DIV cycles. The first BLANK_CYCLES
//   cycles keep every anode off so the previous digit cannot ghost. After that
//   the digit is shown for the rest of the slot. The digit's inputs are sampled
//   once per slot, on the edge that enters the show phase. Leading zeros can be
//   suppressed, and all pin outputs come straight from registers.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   synchronous, active-high reset
//   digit_val   in  16   {d3,d2,d1,d0}; d3 is the leftmost digit
//   digit_en    in   4   per-digit enable (0 = dark for the whole slot)
//   dp_in       in   4   per-digit decimal point request, active-high
//   lz_blank    in   1   1 = suppress leading zeros
//   an          out  4   anodes, active-low; an[i] selects digit i
//   seg         out  7   {a,b,c,d,e,f,g}, active-low
//   dp          out  1   decimal point, active-low
//   scan_idx    out  2   index of the current slot
//   frame_done  out  1   one-cycle pulse after slot 3 ends
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digit_val,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  scan_idx,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       scan_reg, scan_next;
    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;
    logic             frame_reg, frame_next;

    // Active-low abcdefg patterns; values above 9 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0000100;
            default: p = 7'b1111110;
        endcase
        return p;
    endfunction

    // upper_zero[i] is set when every nibble from d3 down to di is zero,
    // i.e. digit i would be a leading zero.
    logic [3:0] nib_zero;
    logic [3:0] upper_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib_zero[gi]   = (digit_val[4*gi +: 4] == 4'h0);
            assign upper_zero[gi] = &nib_zero[3:gi];
        end
    endgenerate

    logic [3:0] cur_nib;
    logic       lz_hit;
    logic       lit;

    assign cur_nib = digit_val[{scan_reg, 2'b00} +: 4];
    // Digit 0 is never suppressed so an all-zero value still shows "0".
    assign lz_hit  = lz_blank && (scan_reg != 2'd0) && upper_zero[scan_reg];
    assign lit     = digit_en[scan_reg] && !lz_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            scan_reg  <= 2'd0;
            an_reg    <= 4'b1111;
            seg_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            scan_reg  <= scan_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            frame_reg <= frame_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        scan_next  = scan_reg;
        an_next    = an_reg;
        seg_next   = seg_reg;
        dp_next    = dp_reg;
        frame_next = 1'b0;

        case (state_reg)
            ST_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    // Sample this slot's digit once; it is held for the whole show phase.
                    state_next = ST_SHOW;
                    if (lit) begin
                        an_next  = ~(4'b0001 << scan_reg);
                        seg_next = seg_decode(cur_nib);
                        dp_next  = ~dp_in[scan_reg];
                    end else begin
                        an_next  = 4'b1111;
                        seg_next = 7'h7F;
                        dp_next  = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    an_next    = 4'b1111;
                    seg_next   = 7'h7F;
                    dp_next    = 1'b1;
                    scan_next  = scan_reg + 2'd1;
                    frame_next = (scan_reg == 2'd3);
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign scan_idx   = scan_reg;
    assign frame_done = frame_reg;

endmodule
